// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared definitions for the UART direction-command decoder.
//   - 2-bit command codes CMD_R/L/U/D (also the FIFO payload)
//   - ASCII constants for R/L/U/D in both cases, plus CR/LF
//   - FSM state enum
//   - decode(): maps a received byte to {is_cmd, is_ign, code}
package uart_cmd_pkg;

  localparam logic [1:0] CMD_R = 2'd0;
  localparam logic [1:0] CMD_L = 2'd1;
  localparam logic [1:0] CMD_U = 2'd2;
  localparam logic [1:0] CMD_D = 2'd3;

  localparam logic [7:0] ASC_R_UC = 8'h52;
  localparam logic [7:0] ASC_R_LC = 8'h72;
  localparam logic [7:0] ASC_L_UC = 8'h4C;
  localparam logic [7:0] ASC_L_LC = 8'h6C;
  localparam logic [7:0] ASC_U_UC = 8'h55;
  localparam logic [7:0] ASC_U_LC = 8'h75;
  localparam logic [7:0] ASC_D_UC = 8'h44;
  localparam logic [7:0] ASC_D_LC = 8'h64;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;

  // Prefixed so the GAP state cannot collide with the GAP parameter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic       is_cmd;  // recognised direction letter
    logic       is_ign;  // CR/LF: silently dropped
    logic [1:0] code;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] b);
    dec_t o;
    o = '0;
    case (b)
      ASC_R_UC, ASC_R_LC: begin o.is_cmd = 1'b1; o.code = CMD_R; end
      ASC_L_UC, ASC_L_LC: begin o.is_cmd = 1'b1; o.code = CMD_L; end
      ASC_U_UC, ASC_U_LC: begin o.is_cmd = 1'b1; o.code = CMD_U; end
      ASC_D_UC, ASC_D_LC: begin o.is_cmd = 1'b1; o.code = CMD_D; end
      ASC_CR, ASC_LF:     o.is_ign = 1'b1;
      default:            o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small synchronous FIFO holding decoded command codes.
//   clk, reset   : clock, async active-high reset (clears pointers/count)
//   push, din    : write din at the write pointer
//   pop, dout    : dout is the head entry; pop advances the read pointer
//   full, empty  : occupancy flags
//   cnt          : registered occupancy
// The caller only pushes when there is room (or a pop happens in the
// same cycle) and only pops when non-empty; nothing is re-checked here.
module cmd_fifo
  import uart_cmd_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr, rd_ptr;

  assign dout  = mem[rd_ptr];
  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: turns received UART bytes R/L/U/D (either case) into
// single-cycle command pulses, queued through a small FIFO and held off
// while a physical button is active.
//   clk, reset        : clock, async active-high reset
//   rx_data, rx_done  : received byte and its one-cycle valid strobe
//   btn_busy          : any physical button active; blocks issue from IDLE
//   r, l, u, d        : one-cycle command pulses (registered)
//   cmd_err           : one-cycle pulse, unrecognised byte
//   overflow          : one-cycle pulse, valid command dropped (FIFO full)
//   fifo_cnt          : current FIFO occupancy
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int GAP   = 2,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_done,
  input  logic          btn_busy,
  output logic          r,
  output logic          l,
  output logic          u,
  output logic          d,
  output logic          cmd_err,
  output logic          overflow,
  output logic [CW-1:0] fifo_cnt
);

  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t        state;
  logic [GW-1:0] gap_cnt;
  dec_t          dec;
  logic          is_cmd, is_err;
  logic          push, pop, full, empty;
  logic [1:0]    head;

  assign dec    = decode(rx_data);
  assign is_cmd = rx_done & dec.is_cmd;
  assign is_err = rx_done & ~dec.is_cmd & ~dec.is_ign;

  // btn_busy only gates the pop decision; a pulse already issued completes.
  assign pop  = (state == ST_IDLE) & ~empty & ~btn_busy;
  // A full FIFO still accepts a push when the head leaves this same cycle.
  assign push = is_cmd & (~full | pop);

  cmd_fifo #(.WIDTH(2), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (dec.code),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .cnt   (fifo_cnt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      gap_cnt      <= '0;
      {d, u, l, r} <= '0;
      cmd_err      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      cmd_err      <= is_err;
      overflow     <= is_cmd & ~push;
      {d, u, l, r} <= '0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            {d, u, l, r} <= 4'b0001 << head;  // code order R,L,U,D = bits 0..3
            state        <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (GAP > 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= ST_GAP;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) state   <= ST_IDLE;
          else               gap_cnt <= gap_cnt - GW'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench: stimulus pushes expected pulse events (kind + cycle)
// into a queue; an independent monitor pops one entry for every pulse the
// DUT produces and compares both kind and cycle.
module tb_uart_cmd_decoder;

  localparam int DEPTH = 4;
  localparam int GAP   = 2;
  localparam int CW    = $clog2(DEPTH + 1);

  // Event mask bits: {overflow, cmd_err, d, u, l, r}
  localparam logic [5:0] M_R   = 6'b000001;
  localparam logic [5:0] M_L   = 6'b000010;
  localparam logic [5:0] M_U   = 6'b000100;
  localparam logic [5:0] M_D   = 6'b001000;
  localparam logic [5:0] M_ERR = 6'b010000;
  localparam logic [5:0] M_OVF = 6'b100000;

  typedef struct {
    logic [5:0] mask;
    int         cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          btn_busy;
  logic          r, l, u, d, cmd_err, overflow;
  logic [CW-1:0] fifo_cnt;

  int  cyc = 0;
  int  n_vec = 0;
  int  n_bad = 0;
  ev_t expq[$];

  uart_cmd_decoder #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .btn_busy (btn_busy),
    .r        (r),
    .l        (l),
    .u        (u),
    .d        (d),
    .cmd_err  (cmd_err),
    .overflow (overflow),
    .fifo_cnt (fifo_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic exp_ev(input logic [5:0] m, input int c);
    ev_t e;
    e.mask = m;
    e.cyc  = c;
    expq.push_back(e);
  endtask

  // Inputs change 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic chk_cnt(input string nm, input int req);
    @(negedge clk);
    chk(nm, 32'(fifo_cnt), 32'(req));
  endtask

  // Monitor: every pulse must match the next expected event.
  always @(negedge clk) begin
    logic [5:0] m;
    ev_t        e;
    if (reset !== 1'b1) begin
      m = {overflow, cmd_err, d, u, l, r};
      if (m != 6'b0) begin
        if (expq.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_pulse: got mask %b required none (cycle %0d)", m, cyc);
        end else begin
          e = expq.pop_front();
          chk("pulse_kind", 32'(m), 32'(e.mask));
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int c0, c1;
    reset    = 1'b1;
    rx_done  = 1'b0;
    rx_data  = 8'h00;
    btn_busy = 1'b0;
    idle(2);
    @(negedge clk);
    chk("reset_outputs", 32'({overflow, cmd_err, d, u, l, r}), 32'd0);
    chk("reset_fifo_cnt", 32'(fifo_cnt), 32'd0);
    tick();
    reset = 1'b0;
    idle(2);

    // Single 'r': pulse two cycles after rx_done.
    c0 = cyc;
    exp_ev(M_R, c0 + 2);
    send(8'h72);
    chk_cnt("single_cnt_n1", 1);
    tick();
    chk_cnt("single_cnt_n2", 0);
    idle(10);

    // Burst U d L R: pulse period is PULSE + GAP cycles + IDLE = 4.
    c0 = cyc;
    exp_ev(M_U, c0 + 2);
    exp_ev(M_D, c0 + 6);
    exp_ev(M_L, c0 + 10);
    exp_ev(M_R, c0 + 14);
    send(8'h55); send(8'h64); send(8'h4C); send(8'h52);
    chk_cnt("burst_cnt_peak", 3);
    idle(20);
    chk_cnt("burst_cnt_drained", 0);

    // Overflow: five commands while held off; fifth dropped.
    btn_busy = 1'b1;
    c0 = cyc;
    exp_ev(M_OVF, c0 + 5);
    send(8'h52); send(8'h4C); send(8'h55); send(8'h44); send(8'h72);
    chk_cnt("ovf_cnt_full", 4);
    idle(3);
    chk_cnt("ovf_cnt_held", 4);
    tick();
    c1 = cyc;
    exp_ev(M_R, c1 + 1);
    exp_ev(M_L, c1 + 5);
    exp_ev(M_U, c1 + 9);
    exp_ev(M_D, c1 + 13);
    btn_busy = 1'b0;
    idle(20);
    chk_cnt("ovf_cnt_drained", 0);

    // Errors and ignores: only 0x41 is an error.
    c0 = cyc;
    exp_ev(M_ERR, c0 + 1);
    send(8'h41); send(8'h0D); send(8'h0A);
    chk_cnt("err_cnt", 0);
    idle(10);
    chk_cnt("err_cnt_later", 0);

    // Button hold-off: 'L' waits for btn_busy to fall.
    btn_busy = 1'b1;
    send(8'h4C);
    idle(19);
    chk_cnt("hold_cnt", 1);
    tick();
    c1 = cyc;
    exp_ev(M_L, c1 + 1);
    btn_busy = 1'b0;
    tick();
    chk_cnt("hold_cnt_after", 0);
    idle(10);

    // Async reset mid-GAP with two entries queued.
    c0 = cyc;
    exp_ev(M_R, c0 + 2);
    send(8'h52); send(8'h55); send(8'h44);
    chk_cnt("pre_reset_cnt", 2);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outputs", 32'({overflow, cmd_err, d, u, l, r}), 32'd0);
    chk("async_reset_cnt", 32'(fifo_cnt), 32'd0);
    idle(2);
    reset = 1'b0;
    idle(20);
    chk_cnt("post_reset_cnt", 0);

    chk("expected_pulses_left", 32'(expq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
